// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one RAM port between the instruction-fetch port and the data port.
//   Data requests win over fetches, except that after MAX_DSTREAK consecutive
//   data grants with a fetch waiting, the fetch is served next. Each access
//   runs IDLE -> ACC -> RESP; a watchdog ends an access that sees no ramready
//   within TIMEOUT cycles, returns BAD_WORD and sets the sticky mem_error.
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   iREN, iaddr         fetch request (held until ihit) and address
//   iload, ihit         fetched word and one-cycle completion pulse
//   dREN, dWEN          data read / write request (held until dhit)
//   daddr, dstore       data address and write data
//   dload, dhit         read word and one-cycle completion pulse
//   ramREN, ramWEN      RAM strobes, only asserted in ACC
//   ramaddr, ramstore   latched address / write data of the current access
//   ramload, ramready   RAM read data and completion
//   mem_error           sticky timeout flag
module mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4,
  parameter int unsigned TIMEOUT     = 64,
  parameter logic [31:0] BAD_WORD    = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        mem_error
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_DSTREAK);
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic        own_d_r;
  logic        wr_r;
  logic [31:0] addr_r;
  logic [31:0] store_r;
  logic [31:0] rdata_r;
  logic [7:0]  timer_r;
  logic [3:0]  dstreak_r;
  logic        mem_error_r;

  logic        dgrant_s;
  logic        igrant_s;
  logic        timeout_s;

  // Grant decision and next-state logic
  always_comb begin
    dgrant_s     = 1'b0;
    igrant_s     = 1'b0;
    timeout_s    = (timer_r == TIMER_LAST);
    next_state_s = state_r;
    // Data wins unless a waiting fetch has already been passed over STREAK_MAX times.
    if ((dREN || dWEN) && !(iREN && (dstreak_r == STREAK_MAX))) begin
      dgrant_s = 1'b1;
    end else begin
      igrant_s = iREN;
    end
    case (state_r)
      IDLE: begin
        if (dgrant_s || igrant_s) begin
          next_state_s = ACC;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACC: begin
        if (ramready || timeout_s) begin
          next_state_s = RESP;
        end else begin
          next_state_s = ACC;
        end
      end
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register plus latched request, watchdog, streak counter and error flag
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= IDLE;
      own_d_r     <= 1'b0;
      wr_r        <= 1'b0;
      addr_r      <= 32'd0;
      store_r     <= 32'd0;
      rdata_r     <= 32'd0;
      timer_r     <= 8'd0;
      dstreak_r   <= 4'd0;
      mem_error_r <= 1'b0;
    end else begin
      state_r <= next_state_s;
      case (state_r)
        IDLE: begin
          timer_r <= 8'd0;
          if (dgrant_s) begin
            own_d_r <= 1'b1;
            wr_r    <= dWEN;   // read+write together is a write
            addr_r  <= daddr;
            store_r <= dstore;
            // Only count data grants that made a fetch wait.
            if (iREN && (dstreak_r != 4'hF)) begin
              dstreak_r <= dstreak_r + 4'd1;
            end else begin
              dstreak_r <= dstreak_r;
            end
          end else if (igrant_s) begin
            own_d_r   <= 1'b0;
            wr_r      <= 1'b0;
            addr_r    <= iaddr;
            dstreak_r <= 4'd0;
          end else begin
            dstreak_r <= dstreak_r;
          end
        end
        ACC: begin
          timer_r <= timer_r + 8'd1;
          if (ramready) begin
            rdata_r <= ramload;
          end else if (timeout_s) begin
            rdata_r     <= BAD_WORD;
            mem_error_r <= 1'b1;
          end else begin
            rdata_r <= rdata_r;
          end
        end
        RESP:    timer_r <= 8'd0;
        default: timer_r <= 8'd0;
      endcase
    end
  end

  // Outputs are pure decodes of registered state
  assign ramREN    = (state_r == ACC) && !wr_r;
  assign ramWEN    = (state_r == ACC) && wr_r;
  assign ramaddr   = addr_r;
  assign ramstore  = store_r;
  assign ihit      = (state_r == RESP) && !own_d_r;
  assign dhit      = (state_r == RESP) && own_d_r;
  assign iload     = ihit ? rdata_r : 32'd0;
  assign dload     = dhit ? rdata_r : 32'd0;
  assign mem_error = mem_error_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized request / RAM
// latency traffic, checked against a transaction-level model of the
// arbitration rules (priority, streak limit, latency, timeout).
module tb_mem_arbiter;

  localparam int          MAXS = 4;
  localparam int          TMO  = 64;
  localparam logic [31:0] BAD  = 32'hBAD1BAD1;

  logic        CLK;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic [31:0] dload;
  logic        dhit;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        ramready;
  logic        mem_error;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit    p_i;
  bit    p_d;
  bit    d_wr;
  int    streak;
  bit    merr;
  string obs_seq;

  mem_arbiter #(.MAX_DSTREAK(MAXS), .TIMEOUT(TMO), .BAD_WORD(BAD)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .mem_error(mem_error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ihit"}, {31'd0, ihit}, 32'd0);
    chk({tag, "_dhit"}, {31'd0, dhit}, 32'd0);
    chk({tag, "_iload"}, iload, 32'd0);
    chk({tag, "_dload"}, dload, 32'd0);
    chk({tag, "_ramREN"}, {31'd0, ramREN}, 32'd0);
    chk({tag, "_ramWEN"}, {31'd0, ramWEN}, 32'd0);
  endtask

  task automatic raise_i(input logic [31:0] a);
    iREN  = 1'b1;
    iaddr = a;
    p_i   = 1'b1;
  endtask

  task automatic raise_d(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] v);
    dREN   = rd;
    dWEN   = wr;
    daddr  = a;
    dstore = v;
    p_d    = 1'b1;
    d_wr   = wr;
  endtask

  // One access starting with the DUT in IDLE. lat = ACC cycles before ramready
  // (ready in ACC cycle lat+1); lat < 0 means the RAM never answers.
  task automatic do_txn(input int lat, input logic [31:0] rdval);
    bit          gd;
    bit          ew;
    bit          done;
    int          k;
    logic [31:0] ea;
    logic [31:0] es;
    logic [31:0] ed;
    gd = p_d && !(p_i && streak == MAXS);
    if (gd) begin
      if (p_i) streak++;
      ea = daddr; es = dstore; ew = d_wr;
    end else begin
      streak = 0;
      ea = iaddr; es = 32'd0; ew = 1'b0;
    end
    ed = 32'd0;
    step();
    k = 1;
    done = 1'b0;
    while (!done) begin
      chk("acc_ramREN", {31'd0, ramREN}, {31'd0, !ew});
      chk("acc_ramWEN", {31'd0, ramWEN}, {31'd0, ew});
      chk("acc_ramaddr", ramaddr, ea);
      if (ew) chk("acc_ramstore", ramstore, es);
      chk("acc_nohit", {30'd0, ihit, dhit}, 32'd0);
      if (lat >= 0 && k == lat + 1) begin
        ramready = 1'b1;
        ramload  = rdval;
        ed       = rdval;
      end
      step();
      if (ramready) begin
        ramready = 1'b0;
        ramload  = $urandom;
        done     = 1'b1;
      end else if (k == TMO) begin
        ed   = BAD;
        merr = 1'b1;
        done = 1'b1;
      end
      k++;
    end
    // response cycle
    chk("resp_ihit", {31'd0, ihit}, {31'd0, !gd});
    chk("resp_dhit", {31'd0, dhit}, {31'd0, gd});
    chk("resp_iload", iload, gd ? 32'd0 : ed);
    chk("resp_dload", dload, gd ? ed : 32'd0);
    chk("resp_strobes", {30'd0, ramREN, ramWEN}, 32'd0);
    chk("resp_mem_error", {31'd0, mem_error}, {31'd0, merr});
    obs_seq = {obs_seq, ihit ? "I" : (dhit ? "D" : "?")};
    if (gd) begin
      dREN = 1'b0; dWEN = 1'b0; p_d = 1'b0;
    end else begin
      iREN = 1'b0; p_i = 1'b0;
    end
    step();
    chk_quiet("idle");
    chk("idle_ramaddr_hold", ramaddr, ea);
  endtask

  initial begin
    RST = 1'b1; iREN = 1'b0; iaddr = 32'd0; dREN = 1'b0; dWEN = 1'b0;
    daddr = 32'd0; dstore = 32'd0; ramload = 32'd0; ramready = 1'b0;
    p_i = 1'b0; p_d = 1'b0; d_wr = 1'b0; streak = 0; merr = 1'b0; obs_seq = "";

    // 1: reset for two cycles, no requests
    step(); step();
    chk_quiet("rst");
    chk("rst_ramaddr", ramaddr, 32'd0);
    chk("rst_ramstore", ramstore, 32'd0);
    chk("rst_mem_error", {31'd0, mem_error}, 32'd0);
    RST = 1'b0;
    step(); step();
    chk_quiet("post_rst");

    // 2: single fetch, ready in first ACC cycle
    raise_i(32'h40);
    do_txn(0, 32'h8C220004);

    // 3: continuous contention -> D,D,D,D,I,D,D,D,D,I
    obs_seq = "";
    for (int n = 0; n < 10; n++) begin
      if (!p_i) raise_i(32'h80 + 32'(n));
      if (!p_d) raise_d(1'b1, 1'b0, 32'h200 + 32'(n), 32'd0);
      do_txn($urandom_range(0, 2), $urandom);
    end
    checks++;
    assert (obs_seq == "DDDDIDDDDI") else begin
      errors++;
      $error("FAIL grant_order observed %s expected DDDDIDDDDI", obs_seq);
    end
    if (p_i) do_txn(0, $urandom);

    // 4: write with a few wait cycles
    raise_d(1'b0, 1'b1, 32'h100, 32'hCAFEF00D);
    do_txn(3, 32'h12345678);

    // randomized traffic
    for (int n = 0; n < 40; n++) begin
      if (!p_i && $urandom_range(0, 1) == 1) raise_i($urandom);
      if (!p_d && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 2))
          0:       raise_d(1'b1, 1'b0, $urandom, $urandom);
          1:       raise_d(1'b0, 1'b1, $urandom, $urandom);
          default: raise_d(1'b1, 1'b1, $urandom, $urandom);
        endcase
      end
      if (!p_i && !p_d) raise_i($urandom);
      do_txn($urandom_range(0, 6), $urandom);
    end
    while (p_i || p_d) do_txn(1, $urandom);

    // 5: timeout, then mem_error stays set across a normal access
    raise_d(1'b1, 1'b0, 32'h300, 32'd0);
    do_txn(-1, 32'd0);
    raise_i(32'h44);
    do_txn(2, 32'h0000BEEF);
    chk("sticky_mem_error", {31'd0, mem_error}, 32'd1);

    // 6: reset during ACC, then a normal fetch
    raise_d(1'b1, 1'b0, 32'h400, 32'd0);
    step();
    chk("pre_rst_ramREN", {31'd0, ramREN}, 32'd1);
    RST = 1'b1;
    step();
    chk_quiet("rst_acc");
    chk("rst_acc_mem_error", {31'd0, mem_error}, 32'd0);
    RST = 1'b0; dREN = 1'b0; p_d = 1'b0; streak = 0; merr = 1'b0;
    step();
    chk_quiet("rst_acc_idle");
    raise_i(32'h48);
    do_txn(1, 32'h8C230008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
